// File: rtl/modn_pkg.sv
// Shared types and helpers for the bit-serial mod-DIV stream checker.
package modn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int rem_width(input int div);
    return $clog2(div);
  endfunction

  // One MSB-first remainder step: rem' = 2*rem + b, folded back below div.
  function automatic int unsigned step(input int unsigned rem, input logic b,
                                       input int unsigned div);
    int unsigned t;
    t = 2 * rem + {31'd0, b};
    return (t >= div) ? (t - div) : t;
  endfunction

endpackage

// File: rtl/modn_step.sv
// Combinational remainder update: next = (2*rem + b) folded below DIV by a
// single conditional subtract, which suffices because rem < DIV always.
module modn_step
  import modn_pkg::*;
#(
  parameter  int DIV = 3,
  localparam int RW  = rem_width(DIV)
) (
  input  logic [RW-1:0] rem,
  input  logic          b,
  output logic [RW-1:0] rem_next
);

  localparam logic [RW:0] DIV_V = (RW + 1)'(DIV);

  logic [RW:0] t;

  always_comb begin
    t        = {rem, b};
    rem_next = (t >= DIV_V) ? RW'(t - DIV_V) : t[RW-1:0];
  end

endmodule

// File: rtl/modn_stream.sv
// Bit-serial divisibility checker with valid/ready on both sides.
// Optional macro MODN_REM_OUT_EN adds the out_rem port carrying the remainder.
module modn_stream
  import modn_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIV   = 3,
  localparam int RW    = rem_width(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_div,
  output state_t           dbg_state
`ifdef MODN_REM_OUT_EN
  ,
  output logic [RW-1:0]    out_rem
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready and valid are decoded from state only, never from the
  // opposite side's input, and results hold steady until taken.

  localparam int CW = $clog2(WIDTH + 1);

  if (DIV < 2) begin : g_bad_div
    $error("modn_stream: DIV must be at least 2");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [RW-1:0]    rem, rem_nxt;
  logic [CW-1:0]    cnt;

  modn_step #(.DIV(DIV)) u_step (
    .rem      (rem),
    .b        (sr[WIDTH-1]),
    .rem_next (rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)                  state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(WIDTH - 1))     state_nxt = DONE;
      DONE:    if (out_ready)                 state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    out_div   = (state == DONE) && (rem == '0);
    dbg_state = state;
`ifdef MODN_REM_OUT_EN
    out_rem   = (state == DONE) ? rem : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sr  <= in_data;
          rem <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          sr  <= sr << 1;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modn_stream.sv
// Bench for modn_stream: four configurations (8/3, 16/7, 8/8, 8/5) checked
// against plain modulo arithmetic; out_rem is checked when MODN_REM_OUT_EN is set.
module tb_modn_stream;
  import modn_pkg::*;

  localparam int WD [4] = '{8, 16, 8, 8};
  localparam int DV [4] = '{3, 7, 8, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, out_ready, in_ready, out_valid, out_div;
  logic [15:0] in_data [4];
  state_t      dbg [4];
  int          cyc = 0;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MODN_REM_OUT_EN
  logic [1:0] rem0;
  logic [2:0] rem1, rem2, rem3;
  logic [2:0] out_rem [4];
  always_comb begin
    out_rem[0] = {1'b0, rem0};
    out_rem[1] = rem1;
    out_rem[2] = rem2;
    out_rem[3] = rem3;
  end
`endif

  modn_stream #(.WIDTH(8), .DIV(3)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][7:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_div(out_div[0]), .dbg_state(dbg[0])
`ifdef MODN_REM_OUT_EN
    , .out_rem(rem0)
`endif
  );

  modn_stream #(.WIDTH(16), .DIV(7)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_div(out_div[1]), .dbg_state(dbg[1])
`ifdef MODN_REM_OUT_EN
    , .out_rem(rem1)
`endif
  );

  modn_stream #(.WIDTH(8), .DIV(8)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_div(out_div[2]), .dbg_state(dbg[2])
`ifdef MODN_REM_OUT_EN
    , .out_rem(rem2)
`endif
  );

  modn_stream #(.WIDTH(8), .DIV(5)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][7:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_div(out_div[3]), .dbg_state(dbg[3])
`ifdef MODN_REM_OUT_EN
    , .out_rem(rem3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one word into instance k, wait for its result, optionally hold
  // out_ready low for 'hold' cycles, then complete the result handshake.
  task automatic send(input int k, input logic [15:0] w, input int hold,
                      output int acc_cyc);
    int          n;
    logic [15:0] wm;
    logic [3:0]  e;
    wm = (WD[k] == 16) ? w : (w & 16'((1 << WD[k]) - 1));
    exp_q.push_back(4'(32'(wm) % DV[k]));
    out_ready[k] = (hold == 0);
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    in_data[k]  = wm;
    @(posedge clk);
    @(negedge clk);
    acc_cyc     = cyc;
    in_valid[k] = 1'b0;
    in_data[k]  = 16'($urandom);
    chk("in_ready_busy", 32'(in_ready[k]), 32'd0);
    n = 0;
    while (!out_valid[k] && n < 100) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk("latency", 32'(n), 32'(WD[k]));
    e = exp_q.pop_front();
    chk("out_div", 32'(out_div[k]), 32'(e == 4'd0));
`ifdef MODN_REM_OUT_EN
    chk("out_rem", 32'(out_rem[k]), 32'(e));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(out_valid[k]), 32'd1);
      chk("hold_div", 32'(out_div[k]), 32'(e == 4'd0));
      chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
`ifdef MODN_REM_OUT_EN
      chk("hold_rem", 32'(out_rem[k]), 32'(e));
`endif
    end
    out_ready[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_valid", 32'(out_valid[k]), 32'd0);
    chk("post_in_ready", 32'(in_ready[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, prev, seen;
    logic [15:0] dir0 [4];
    dir0 = '{16'h00, 16'hFF, 16'h07, 16'h80};

    // Reset with in_valid high: nothing may be accepted.
    rst       = 1'b1;
    in_valid  = 4'hF;
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++) in_data[k] = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 4'h0;
    rst      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_out_div", 32'(out_div[k]), 32'd0);
      chk("rst_state", 32'(dbg[k]), 32'(IDLE));
`ifdef MODN_REM_OUT_EN
      chk("rst_out_rem", 32'(out_rem[k]), 32'd0);
`endif
    end

    // Back-to-back directed words on 8/3: spacing must be WIDTH+2.
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, dir0[i], 0, a);
      if (i > 0) chk("spacing", 32'(a - prev), 32'd10);
      prev = a;
    end

    send(1, 16'hFFFF, 0, a);
    send(1, 16'hFFFE, 0, a);
    send(2, 16'd200, 0, a);
    send(2, 16'd203, 0, a);
    send(3, 16'd42, 6, a);

    // Reset in the middle of SHIFT discards the word.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'h55;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("midrst_state", 32'(dbg[0]), 32'(IDLE));
    seen = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (out_valid[0]) seen = 1;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    send(0, 16'h03, 0, a);

    // Boundary words and randomized traffic on every configuration.
    for (int k = 0; k < 4; k++) begin
      send(k, 16'h0000, 0, a);
      send(k, 16'hFFFF, 1, a);
      for (int i = 0; i < 25; i++)
        send(k, 16'($urandom), $urandom_range(0, 3), a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
